ecc_lockstep_chk: RTL and testbench

- Registered, parametrised successor to the dual-decoder SECDED fault detector.
- Two identical SECDED decoders run in lockstep on each beat, and their syndrome outputs (mask, sbit, dbit) are compared.
- On mismatch, raw data is forwarded and a fault is flagged.
- Adds:
  - a valid/ready pipeline stage;
  - a saturating fault counter with threshold alarm;
  - a self-test FSM that injects a comparator fault to prove the checker is alive.
- Sits on the read-data path of FIFO/RAM wrappers, between storage and consumer.

---
 rtl/ecc_pkg.sv | 23 ++
 rtl/ecc_secded_dec.sv | 61 ++++++
 rtl/ecc_lockstep_chk.sv | 190 +++++++++++++++++++
 tb/tb_ecc_lockstep_chk.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared types and helpers for the lockstep SECDED checker.
package ecc_pkg;

    // Self-test sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        DONE = 2'd2
    } st_e;

    // Smallest p with 2^(p-1) >= data_width + p (Hamming bits plus overall parity).
    function automatic int unsigned ecc_parity_width(input int unsigned data_width);
        int unsigned res;
        res = 0;
        for (int unsigned p = 2; p < 32; p++) begin
            if ((res == 0) && ((32'd1 << (p - 1)) >= (data_width + p))) begin
                res = p;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ecc_secded_dec.sv
// Combinational SECDED decoder: Hamming check bits at power-of-two codeword
// positions, data in the remaining positions, plus one overall-parity bit (MSB).
module ecc_secded_dec
    import ecc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 109,
    parameter int unsigned PARITY_WIDTH = ecc_parity_width(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [PARITY_WIDTH-1:0] parity_in,
    input  logic                    bypass,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [DATA_WIDTH-1:0]   mask,
    output logic                    sbit_err,
    output logic                    dbit_err
);

    localparam int unsigned HW = PARITY_WIDTH - 1;

    logic [HW-1:0] syn;
    logic          ovr;

    // Syndrome, overall parity, correction mask and error classification.
    always_comb begin
        int unsigned pos;
        syn      = parity_in[HW-1:0];
        mask     = '0;
        ovr      = ^{data_in, parity_in};
        sbit_err = 1'b0;
        dbit_err = 1'b0;

        pos = 1;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if ((pos & (pos - 1)) == '0) pos++;
            if ((pos & (pos - 1)) == '0) pos++;
            if (data_in[i]) syn = syn ^ HW'(pos);
            pos++;
        end

        // Only a single error (odd overall parity) is corrected.
        pos = 1;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if ((pos & (pos - 1)) == '0) pos++;
            if ((pos & (pos - 1)) == '0) pos++;
            mask[i] = ovr & (syn == HW'(pos));
            pos++;
        end

        sbit_err = ovr;
        dbit_err = ~ovr & (syn != '0);

        if (bypass) begin
            mask     = '0;
            sbit_err = 1'b0;
            dbit_err = 1'b0;
        end

        data_out = data_in ^ mask;
    end

endmodule

// File: rtl/ecc_lockstep_chk.sv
// Dual SECDED decoders in lockstep with a registered output stage, saturating
// fault counter with sticky alarm, and a comparator self-test sequencer.
module ecc_lockstep_chk
    import ecc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 109,
    parameter int unsigned PARITY_WIDTH = 8,
    parameter int unsigned CNT_WIDTH    = 8,
    parameter int unsigned ALARM_THRESH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [PARITY_WIDTH-1:0] parity_in,
    input  logic                    bypass,
    input  logic                    chk_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    sbit_err,
    output logic                    dbit_err,
    output logic                    ecc_fault,
    output logic [CNT_WIDTH-1:0]    fault_cnt,
    output logic                    fault_alarm,
    input  logic                    clr_status,
    input  logic                    selftest_req,
    output logic                    selftest_busy,
    output logic                    selftest_pass,
    output logic                    selftest_fail
);

    logic [DATA_WIDTH-1:0] data0, data1, mask0, mask1, mask1_adj;
    logic                  sbit0, dbit0, sbit1, dbit1;
    logic                  inject, cmp_ok, fault_c, sel_dec, accept;
    logic                  unused_data1;

    st_e                   state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  sbit_q, sbit_d, dbit_q, dbit_d, fault_q, fault_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  alarm_q, alarm_d;
    logic                  busy_q, busy_d, pass_q, pass_d, fail_q, fail_d;

    ecc_secded_dec #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u0 (
        .data_in  (data_in),
        .parity_in(parity_in),
        .bypass   (bypass),
        .data_out (data0),
        .mask     (mask0),
        .sbit_err (sbit0),
        .dbit_err (dbit0)
    );

    ecc_secded_dec #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u1 (
        .data_in  (data_in),
        .parity_in(parity_in),
        .bypass   (bypass),
        .data_out (data1),
        .mask     (mask1),
        .sbit_err (sbit1),
        .dbit_err (dbit1)
    );

    // Decoder 1 data is redundant with its mask; only the syndrome is compared.
    assign unused_data1 = ^data1;

    // Lockstep compare with optional injected mismatch, and output select.
    assign inject    = (state_q == ARM);
    assign mask1_adj = mask1 ^ DATA_WIDTH'(inject);
    assign cmp_ok    = ({sbit0, dbit0, mask0} == {sbit1, dbit1, mask1_adj});
    assign fault_c   = ~cmp_ok & chk_en & ~inject;
    assign sel_dec   = cmp_ok | ~chk_en | inject;

    assign in_ready  = ~out_valid_q | out_ready;
    assign accept    = in_valid & in_ready;

    // Next-state for output stage, counter/alarm and self-test sequencer.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        sbit_d      = sbit_q;
        dbit_d      = dbit_q;
        fault_d     = fault_q;
        cnt_d       = cnt_q;
        alarm_d     = alarm_q;
        busy_d      = busy_q;
        pass_d      = pass_q;
        fail_d      = fail_q;

        if (accept) begin
            out_valid_d = 1'b1;
            data_d      = sel_dec ? data0 : data_in;
            sbit_d      = sbit0;
            dbit_d      = dbit0;
            fault_d     = fault_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept && fault_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        if (clr_status) begin
            cnt_d   = '0;
            alarm_d = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
        end

        if (cnt_d >= CNT_WIDTH'(ALARM_THRESH)) begin
            alarm_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (selftest_req) begin
                    state_d = ARM;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            ARM: begin
                if (accept) begin
                    state_d = DONE;
                    pass_d  = ~cmp_ok;
                    fail_d  = cmp_ok;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Self-test state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Output stage, counter and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            sbit_q      <= 1'b0;
            dbit_q      <= 1'b0;
            fault_q     <= 1'b0;
            cnt_q       <= '0;
            alarm_q     <= 1'b0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            sbit_q      <= sbit_d;
            dbit_q      <= dbit_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
            alarm_q     <= alarm_d;
            busy_q      <= busy_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign data_out      = data_q;
    assign sbit_err      = sbit_q;
    assign dbit_err      = dbit_q;
    assign ecc_fault     = fault_q;
    assign fault_cnt     = cnt_q;
    assign fault_alarm   = alarm_q;
    assign selftest_busy = busy_q;
    assign selftest_pass = pass_q;
    assign selftest_fail = fail_q;

endmodule

// File: tb/tb_ecc_lockstep_chk.sv
// Directed bench for ecc_lockstep_chk: decode vector table plus hand sequences
// for fault counting, backpressure, self-test, saturation and reset.
module tb_ecc_lockstep_chk;
    import ecc_pkg::*;

    localparam int unsigned DW = 109;
    localparam int unsigned PW = 8;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, bypass, chk_en, out_ready;
    logic          clr_status, selftest_req;
    logic [DW-1:0] data_in;
    logic [PW-1:0] parity_in;

    logic          in_ready, out_valid, sbit_err, dbit_err, ecc_fault;
    logic          fault_alarm, st_busy, st_pass, st_fail;
    logic [DW-1:0] data_out;
    logic [7:0]    fault_cnt;

    logic          s_in_ready, s_out_valid, s_sbit, s_dbit, s_fault;
    logic          s_alarm, s_busy, s_pass, s_fail;
    logic [DW-1:0] s_data_out;
    logic [1:0]    s_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ecc_lockstep_chk #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(8), .ALARM_THRESH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .parity_in(parity_in), .bypass(bypass), .chk_en(chk_en),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .sbit_err(sbit_err), .dbit_err(dbit_err), .ecc_fault(ecc_fault),
        .fault_cnt(fault_cnt), .fault_alarm(fault_alarm), .clr_status(clr_status),
        .selftest_req(selftest_req), .selftest_busy(st_busy),
        .selftest_pass(st_pass), .selftest_fail(st_fail)
    );

    ecc_lockstep_chk #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(2), .ALARM_THRESH(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .data_in(data_in), .parity_in(parity_in), .bypass(bypass), .chk_en(chk_en),
        .out_valid(s_out_valid), .out_ready(out_ready), .data_out(s_data_out),
        .sbit_err(s_sbit), .dbit_err(s_dbit), .ecc_fault(s_fault),
        .fault_cnt(s_cnt), .fault_alarm(s_alarm), .clr_status(clr_status),
        .selftest_req(selftest_req), .selftest_busy(s_busy),
        .selftest_pass(s_pass), .selftest_fail(s_fail)
    );

    // Reference encoder: build the codeword explicitly, then derive each check bit.
    function automatic logic [PW-1:0] enc(input logic [DW-1:0] d);
        logic [127:0]  cw;
        logic [PW-1:0] par;
        int            k;
        cw  = '0;
        par = '0;
        k   = 0;
        for (int p = 1; p <= 116; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 7; j++) begin
            for (int p = 1; p <= 116; p++) begin
                if (((p >> j) & 1) == 1) par[j] = par[j] ^ cw[p];
            end
        end
        par[7] = (^d) ^ (^par[6:0]);
        return par;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic [PW-1:0] p;
        logic          byp;
        logic          ce;
        logic [DW-1:0] ed;
        logic          es;
        logic          edb;
        logic          ef;
    } vec_t;

    vec_t          tv[11];
    logic [DW-1:0] one, d0, d1, ones, dx, dy, dz, derr;

    initial begin
        one  = 1;
        d0   = 109'h1234;
        d1   = 109'h1DEADBEEFCAFE0123456789ABCD;
        ones = '1;

        tv[0]  = '{d0,                            enc(d0),           1'b0, 1'b1, d0,                            1'b0, 1'b0, 1'b0};
        tv[1]  = '{d0 ^ (one << 57),              enc(d0),           1'b0, 1'b1, d0,                            1'b1, 1'b0, 1'b0};
        tv[2]  = '{d0 ^ (one << 3) ^ (one << 90), enc(d0),           1'b0, 1'b1, d0 ^ (one << 3) ^ (one << 90), 1'b0, 1'b1, 1'b0};
        tv[3]  = '{d0,                            enc(d0) ^ 8'h04,   1'b0, 1'b1, d0,                            1'b1, 1'b0, 1'b0};
        tv[4]  = '{d0,                            enc(d0) ^ 8'h80,   1'b0, 1'b1, d0,                            1'b1, 1'b0, 1'b0};
        tv[5]  = '{d0 ^ (one << 57),              enc(d0),           1'b1, 1'b1, d0 ^ (one << 57),              1'b0, 1'b0, 1'b0};
        tv[6]  = '{ones,                          enc(ones),         1'b0, 1'b1, ones,                          1'b0, 1'b0, 1'b0};
        tv[7]  = '{ones ^ one,                    enc(ones),         1'b0, 1'b1, ones,                          1'b1, 1'b0, 1'b0};
        tv[8]  = '{d1 ^ (one << 108),             enc(d1),           1'b0, 1'b1, d1,                            1'b1, 1'b0, 1'b0};
        tv[9]  = '{d1,                            enc(d1),           1'b0, 1'b0, d1,                            1'b0, 1'b0, 1'b0};
        tv[10] = '{d1 ^ (one << 20) ^ (one << 21), enc(d1),          1'b0, 1'b1, d1 ^ (one << 20) ^ (one << 21), 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; bypass = 1'b0; chk_en = 1'b1; out_ready = 1'b1;
        clr_status = 1'b0; selftest_req = 1'b0; data_in = '0; parity_in = '0;
        tick(); tick();

        // Reset state
        chk("rst out_valid", 128'(out_valid), 128'(0));
        chk("rst data_out", 128'(data_out), 128'(0));
        chk("rst flags", 128'({sbit_err, dbit_err, ecc_fault, fault_alarm}), 128'(0));
        chk("rst fault_cnt", 128'(fault_cnt), 128'(0));
        chk("rst selftest", 128'({st_busy, st_pass, st_fail}), 128'(0));
        chk("rst in_ready", 128'(in_ready), 128'(1));
        rst_n = 1'b1;

        // Decode table, one beat per cycle
        for (int i = 0; i < 11; i++) begin
            data_in = tv[i].d; parity_in = tv[i].p; bypass = tv[i].byp; chk_en = tv[i].ce;
            in_valid = 1'b1;
            tick();
            chk($sformatf("v%0d out_valid", i), 128'(out_valid), 128'(1));
            chk($sformatf("v%0d data_out", i), 128'(data_out), 128'(tv[i].ed));
            chk($sformatf("v%0d sbit", i), 128'(sbit_err), 128'(tv[i].es));
            chk($sformatf("v%0d dbit", i), 128'(dbit_err), 128'(tv[i].edb));
            chk($sformatf("v%0d fault", i), 128'(ecc_fault), 128'(tv[i].ef));
            chk($sformatf("v%0d cnt", i), 128'(fault_cnt), 128'(0));
        end
        in_valid = 1'b0; bypass = 1'b0; chk_en = 1'b1;
        tick();

        // Lockstep mismatch: count up to the alarm threshold
        force dut.u1.mask = 109'h8;
        force u_sat.u1.mask = 109'h8;
        derr = d0 ^ (one << 57);
        data_in = derr; parity_in = enc(d0); in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("flt%0d fault", k), 128'(ecc_fault), 128'(1));
            chk($sformatf("flt%0d data_out", k), 128'(data_out), 128'(derr));
            chk($sformatf("flt%0d cnt", k), 128'(fault_cnt), 128'(k));
            chk($sformatf("flt%0d alarm", k), 128'(fault_alarm), 128'(k >= 4));
            chk($sformatf("flt%0d sat cnt", k), 128'(s_cnt), 128'((k > 3) ? 3 : k));
            chk($sformatf("flt%0d sat alarm", k), 128'(s_alarm), 128'(k >= 3));
        end
        chk_en = 1'b0;
        tick();
        chk("chk_en0 fault", 128'(ecc_fault), 128'(0));
        chk("chk_en0 data_out", 128'(data_out), 128'(d0));
        chk("chk_en0 cnt", 128'(fault_cnt), 128'(4));
        chk_en = 1'b1; clr_status = 1'b1;
        tick();
        chk("clr+fault fault", 128'(ecc_fault), 128'(1));
        chk("clr+fault cnt", 128'(fault_cnt), 128'(0));
        chk("clr+fault alarm", 128'(fault_alarm), 128'(0));
        clr_status = 1'b0; in_valid = 1'b0;
        release dut.u1.mask;
        release u_sat.u1.mask;
        tick();
        chk("drain out_valid", 128'(out_valid), 128'(0));

        // Backpressure: hold a beat for three cycles, then resume at full rate
        dx = 109'hA5A5; dy = 109'h5A5A; dz = 109'h0F0F0;
        out_ready = 1'b0; data_in = dx; parity_in = enc(dx); in_valid = 1'b1;
        tick();
        chk("bp load data", 128'(data_out), 128'(dx));
        data_in = dy; parity_in = enc(dy);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp%0d in_ready", k), 128'(in_ready), 128'(0));
            tick();
            chk($sformatf("bp%0d hold", k), 128'({out_valid, data_out}), 128'({1'b1, dx}));
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 128'(in_ready), 128'(1));
        tick();
        chk("bp next data", 128'(data_out), 128'(dy));
        data_in = dz; parity_in = enc(dz);
        tick();
        chk("bp back-to-back", 128'(data_out), 128'(dz));
        in_valid = 1'b0;
        tick();

        // Self-test pass path
        selftest_req = 1'b1;
        tick();
        selftest_req = 1'b0;
        chk("st armed busy", 128'(st_busy), 128'(1));
        tick();
        chk("st wait busy", 128'({st_busy, st_pass}), 128'({1'b1, 1'b0}));
        data_in = d0; parity_in = enc(d0); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("st pass", 128'({st_pass, st_fail}), 128'({1'b1, 1'b0}));
        chk("st beat fault", 128'(ecc_fault), 128'(0));
        chk("st beat data", 128'(data_out), 128'(d0));
        chk("st beat cnt", 128'(fault_cnt), 128'(0));
        tick();
        chk("st done busy", 128'({st_busy, st_pass}), 128'({1'b0, 1'b1}));
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("st clr", 128'({st_pass, st_fail}), 128'(0));

        // Self-test fail path with injection suppressed
        force dut.inject = 1'b0;
        force u_sat.inject = 1'b0;
        selftest_req = 1'b1;
        tick();
        selftest_req = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("st fail", 128'({st_pass, st_fail}), 128'({1'b0, 1'b1}));
        release dut.inject;
        release u_sat.inject;
        tick();

        // Self-test under bypass with chk_en low still passes
        selftest_req = 1'b1;
        tick();
        selftest_req = 1'b0;
        data_in = derr; parity_in = enc(d0); bypass = 1'b1; chk_en = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; bypass = 1'b0; chk_en = 1'b1;
        chk("st bypass pass", 128'({st_pass, st_fail}), 128'({1'b1, 1'b0}));
        chk("st bypass data", 128'({data_out, sbit_err}), 128'({derr, 1'b0}));
        tick(); tick();

        // Saturation at CNT_WIDTH=2
        force dut.u1.mask = 109'h8;
        force u_sat.u1.mask = 109'h8;
        data_in = d0; parity_in = enc(d0); in_valid = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        in_valid = 1'b0;
        release dut.u1.mask;
        release u_sat.u1.mask;
        chk("sat cnt", 128'(s_cnt), 128'(3));
        chk("sat alarm", 128'(s_alarm), 128'(1));
        chk("wide cnt", 128'(fault_cnt), 128'(5));

        // Reset while a beat is held and the self-test is armed
        out_ready = 1'b0; selftest_req = 1'b1;
        tick();
        selftest_req = 1'b0;
        chk("pre-rst held", 128'({out_valid, st_busy}), 128'({1'b1, 1'b1}));
        rst_n = 1'b0;
        tick();
        chk("mid-rst out_valid", 128'(out_valid), 128'(0));
        chk("mid-rst data", 128'(data_out), 128'(0));
        chk("mid-rst flags", 128'({sbit_err, dbit_err, ecc_fault, fault_alarm}), 128'(0));
        chk("mid-rst cnt", 128'({fault_cnt, s_cnt}), 128'(0));
        chk("mid-rst selftest", 128'({st_busy, st_pass, st_fail}), 128'(0));
        chk("mid-rst fsm", 128'(dut.state_q), 128'(IDLE));
        rst_n = 1'b1; out_ready = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
